// File: rtl/generation_sequencer.sv
// Lock/run controller for the clock-generation datapath: acquires lock, clears and aligns generation, monitors drift.
// Optional GENERATION_SEQUENCER_STATS_EN adds resync_count_o and max_drift_o statistics outputs.
module generation_sequencer #(
    parameter int W          = 16,  // matches clks_alot_p::RATE_COUNTER_WIDTH
    parameter int LOCK_EDGES = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic         clk,
    input  logic         async_rst,
    input  logic         clk_en,
    input  logic         enable_i,
    input  logic         recovered_edge_i,
    input  logic         deltas_locked_in_i,
    input  logic [W-1:0] half_rate_target_i,
    input  logic [W-1:0] counter_current_i,
    input  logic [W-1:0] tolerance_i,
    output logic         generation_en_o,
    output logic         clear_state_o,
    output logic         locked_o,
`ifdef GENERATION_SEQUENCER_STATS_EN
    output logic [7:0]   resync_count_o,
    output logic [W:0]   max_drift_o,
`endif
    output logic [2:0]   state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACQUIRE = 3'd1,
        S_ARM     = 3'd2,
        S_ALIGN   = 3'd3,
        S_RUN     = 3'd4,
        S_RESYNC  = 3'd5
    } state_e;

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_EDGES - 1);
    localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);

    state_e       state_q, state_d;
    logic [3:0]   lock_cnt_q, lock_cnt_d;
    logic [3:0]   miss_cnt_q, miss_cnt_d;
    logic         gen_en_q, clear_q, locked_q;
    logic         clear_d, abort, miss;
    logic [W-1:0] drift;
    logic [W:0]   mag;

    // Modular difference, so counter/target wrap across 2^W still yields a small drift.
    assign drift = counter_current_i - half_rate_target_i;
    assign mag   = drift[W-1] ? ({1'b0, ~drift} + {{W{1'b0}}, 1'b1}) : {1'b0, drift};
    assign miss  = mag > {1'b0, tolerance_i};
    assign abort = (state_q != S_IDLE) && !enable_i;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (enable_i) begin
                    state_d    = S_ACQUIRE;
                    lock_cnt_d = '0;
                end
                S_ACQUIRE: if (!deltas_locked_in_i) begin
                    lock_cnt_d = '0;
                end else if (recovered_edge_i) begin
                    if (lock_cnt_q == LOCK_LAST) state_d = S_ARM;
                    else lock_cnt_d = lock_cnt_q + 4'd1;
                end
                S_ARM: state_d = S_ALIGN;
                S_ALIGN: if (!deltas_locked_in_i) begin
                    state_d    = S_ACQUIRE;
                    lock_cnt_d = '0;
                end else if (recovered_edge_i) begin
                    state_d    = S_RUN;
                    miss_cnt_d = '0;
                end
                S_RUN: if (!deltas_locked_in_i) begin
                    state_d = S_RESYNC;
                end else if (recovered_edge_i) begin
                    if (!miss) miss_cnt_d = '0;
                    else if (miss_cnt_q == MISS_LAST) state_d = S_RESYNC;
                    else miss_cnt_d = miss_cnt_q + 4'd1;
                end
                S_RESYNC: begin
                    state_d    = S_ACQUIRE;
                    lock_cnt_d = '0;
                    miss_cnt_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // An abort straight out of ARM/RESYNC already had its clear cycle; never stretch it to two.
    assign clear_d = (state_d == S_ARM) || (state_d == S_RESYNC) ||
                     (abort && (state_q != S_ARM) && (state_q != S_RESYNC));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q    <= S_IDLE;
            lock_cnt_q <= '0;
            miss_cnt_q <= '0;
            gen_en_q   <= 1'b0;
            clear_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            gen_en_q   <= (state_d == S_RUN);
            clear_q    <= clear_d;
            locked_q   <= (state_d == S_RUN);
        end
    end

    assign generation_en_o = gen_en_q;
    assign clear_state_o   = clear_q;
    assign locked_o        = locked_q;
    assign state_o         = state_q;

`ifdef GENERATION_SEQUENCER_STATS_EN
    logic [7:0] resync_cnt_q;
    logic [W:0] max_drift_q;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            resync_cnt_q <= '0;
            max_drift_q  <= '0;
        end else if (clk_en) begin
            if ((state_q == S_RUN) && (state_d == S_RESYNC) && (resync_cnt_q != 8'hFF))
                resync_cnt_q <= resync_cnt_q + 8'd1;
            if (state_d == S_ARM)
                max_drift_q <= '0;
            else if ((state_q == S_RUN) && recovered_edge_i && (mag > max_drift_q))
                max_drift_q <= mag;
        end
    end

    assign resync_count_o = resync_cnt_q;
    assign max_drift_o    = max_drift_q;
`endif

endmodule
